// File: rtl/fetch_pc_select.sv
// Fetch-side PC selection for the Y86-64 pipeline: owns F_predPC, picks f_pc,
// suppresses fetch after ret/halt and counts issued fetches.
module fetch_pc_select #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       f_icode,
  input  logic [63:0]      f_valC,
  input  logic [63:0]      f_valP,
  input  logic             f_imem_error,
  input  logic             F_stall,
  input  logic [3:0]       M_icode,
  input  logic             M_cnd,
  input  logic [63:0]      M_valA,
  input  logic [3:0]       W_icode,
  input  logic [63:0]      W_valM,
  output logic [63:0]      f_pc,
  output logic             f_bubble,
  output logic [63:0]      F_predPC,
  output logic             halted,
  output logic             ret_pending,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [3:0]       I_HALT  = 4'd0;
  localparam logic [3:0]       I_JXX   = 4'd7;
  localparam logic [3:0]       I_CALL  = 4'd8;
  localparam logic [3:0]       I_RET   = 4'd9;
  localparam logic [3:0]       I_MAX   = 4'd11;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RET_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t           state_reg, state_next, eff_state;
  logic [63:0]      pred_reg;
  logic [CNT_W-1:0] count_reg;
  logic             mispredict, wret, issue;
  logic [63:0]      pred;

  assign mispredict = (M_icode == I_JXX) && !M_cnd;
  assign wret       = (W_icode == I_RET);

  assign f_pc = mispredict ? M_valA :
                wret       ? W_valM : pred_reg;

  assign pred = ((f_icode == I_JXX) || (f_icode == I_CALL)) ? f_valC : f_valP;

  // A mispredict means any pending ret/halt was on the wrong path.
  always_comb begin
    eff_state = state_reg;
    if (mispredict)
      eff_state = RUN;
    else if ((state_reg == RET_WAIT) && wret)
      eff_state = RUN;
  end

  assign f_bubble = (eff_state != RUN);
  assign issue    = !f_bubble && (!F_stall || mispredict);

  always_comb begin
    state_next = eff_state;
    if (issue) begin
      if (f_imem_error || (f_icode > I_MAX) || (f_icode == I_HALT))
        state_next = HALT;
      else if (f_icode == I_RET)
        state_next = RET_WAIT;
      else
        state_next = RUN;
    end else if (F_stall && wret && !mispredict && (state_reg == RET_WAIT)) begin
      // A stalled ret release is not consumed; wait for it to be presented again.
      state_next = RET_WAIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_reg  <= RESET_PC;
      state_reg <= RUN;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (issue) begin
        pred_reg  <= pred;
        count_reg <= count_reg + CNT_ONE;
      end
    end
  end

  assign F_predPC    = pred_reg;
  assign halted      = (state_reg == HALT);
  assign ret_pending = (state_reg == RET_WAIT);
  assign fetch_count = count_reg;

endmodule

// File: tb/tb_fetch_pc_select.sv
// Randomised and directed bench for fetch_pc_select; a reference model queues
// expected outputs and a negedge monitor compares them against two instances.
module tb_fetch_pc_select;

  localparam logic [63:0] RPC = 64'h100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  f_icode = 4'd1;
  logic [63:0] f_valC = '0, f_valP = '0;
  logic        f_imem_error = 1'b0, F_stall = 1'b0;
  logic [3:0]  M_icode = 4'd1;
  logic        M_cnd = 1'b1;
  logic [63:0] M_valA = '0;
  logic [3:0]  W_icode = 4'd1;
  logic [63:0] W_valM = '0;

  logic [63:0] f_pc, F_predPC, f_pc2, F_predPC2;
  logic        f_bubble, halted, ret_pending, f_bubble2, halted2, ret_pending2;
  logic [31:0] fetch_count;
  logic [2:0]  fetch_count2;

  always #5 clk = ~clk;

  fetch_pc_select #(.RESET_PC(RPC), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
    .f_imem_error(f_imem_error), .F_stall(F_stall), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valA(M_valA), .W_icode(W_icode), .W_valM(W_valM), .f_pc(f_pc),
    .f_bubble(f_bubble), .F_predPC(F_predPC), .halted(halted),
    .ret_pending(ret_pending), .fetch_count(fetch_count)
  );

  // Narrow counter instance exercises modulo wrap in a short run.
  fetch_pc_select #(.RESET_PC(RPC), .CNT_W(3)) dut_w (
    .clk(clk), .reset(reset), .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
    .f_imem_error(f_imem_error), .F_stall(F_stall), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valA(M_valA), .W_icode(W_icode), .W_valM(W_valM), .f_pc(f_pc2),
    .f_bubble(f_bubble2), .F_predPC(F_predPC2), .halted(halted2),
    .ret_pending(ret_pending2), .fetch_count(fetch_count2)
  );

  typedef struct {
    int          id;
    logic [63:0] pc;
    logic        bub;
    logic [63:0] pred;
    logic        hlt;
    logic        rw;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  // Reference model: mode 0 = fetching, 1 = waiting on ret, 2 = halted.
  int          m_mode;
  logic [63:0] m_pred;
  logic [31:0] m_cnt;

  task automatic chk(string name, int id, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s txn=%0d got=%h expected=%h", name, id, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("txn %0d f_pc=%h bub=%0d pred=%h halt=%0d retw=%0d cnt=%0d",
               e.id, f_pc, f_bubble, F_predPC, halted, ret_pending, fetch_count);
      chk("f_pc", e.id, f_pc, e.pc);
      chk("f_bubble", e.id, 64'(f_bubble), 64'(e.bub));
      chk("F_predPC", e.id, F_predPC, e.pred);
      chk("halted", e.id, 64'(halted), 64'(e.hlt));
      chk("ret_pending", e.id, 64'(ret_pending), 64'(e.rw));
      chk("fetch_count", e.id, 64'(fetch_count), 64'(e.cnt));
      chk("w_f_pc", e.id, f_pc2, e.pc);
      chk("w_f_bubble", e.id, 64'(f_bubble2), 64'(e.bub));
      chk("w_F_predPC", e.id, F_predPC2, e.pred);
      chk("w_halted", e.id, 64'(halted2), 64'(e.hlt));
      chk("w_ret_pending", e.id, 64'(ret_pending2), 64'(e.rw));
      chk("w_fetch_count_wrap", e.id, 64'(fetch_count2), 64'(e.cnt % 8));
    end
  end

  // Called just after a rising edge: predicts this cycle's outputs, then the next edge.
  task automatic step();
    exp_t e;
    bit   mp, wr, running, issue;
    int   next_mode;
    if (reset) begin
      m_mode = 0; m_pred = RPC; m_cnt = 0;
    end
    mp = (M_icode == 4'd7) && !M_cnd;
    wr = (W_icode == 4'd9);
    running = mp || (m_mode == 0) || (m_mode == 1 && wr);
    issue = running && (!F_stall || mp);
    e.id   = txn++;
    e.pc   = mp ? M_valA : (wr ? W_valM : m_pred);
    e.bub  = !running;
    e.pred = m_pred;
    e.hlt  = (m_mode == 2);
    e.rw   = (m_mode == 1);
    e.cnt  = m_cnt;
    exp_q.push_back(e);
    if (!reset) begin
      if (issue) begin
        m_pred = (f_icode == 4'd7 || f_icode == 4'd8) ? f_valC : f_valP;
        m_cnt  = m_cnt + 1;
        if (f_imem_error || f_icode == 4'd0 || f_icode > 4'd11) next_mode = 2;
        else if (f_icode == 4'd9) next_mode = 1;
        else next_mode = 0;
        m_mode = next_mode;
      end else if (running && !(m_mode == 1 && F_stall && !mp)) begin
        m_mode = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp);
    f_icode = ic; f_valC = vc; f_valP = vp;
    step();
  endtask

  task automatic quiet();
    M_icode = 4'd1; M_cnd = 1'b1; W_icode = 4'd1; F_stall = 1'b0; f_imem_error = 1'b0;
  endtask

  initial begin
    m_mode = 0; m_pred = RPC; m_cnt = 0;
    @(posedge clk); #1;
    step(); step();
    reset = 1'b0;
    // Sequential irmovq run.
    repeat (3) fetch(4'd3, 64'h0, 64'h10A);
    fetch(4'd3, 64'h0, 64'h20);
    // Taken-predicted jXX at 0x20, resolved not-taken two cycles later.
    fetch(4'd7, 64'h80, 64'h29);
    fetch(4'd3, 64'h0, 64'h8A);
    M_icode = 4'd7; M_cnd = 1'b0; M_valA = 64'h29;
    fetch(4'd3, 64'h0, 64'h33);
    quiet();
    // ret at 0x40, released by W.
    fetch(4'd3, 64'h0, 64'h40);
    fetch(4'd9, 64'h0, 64'h41);
    repeat (3) fetch(4'd6, 64'h0, 64'h99);
    W_icode = 4'd9; W_valM = 64'h55;
    fetch(4'd3, 64'h0, 64'h5F);
    quiet();
    // Wrong-path ret cancelled by mispredict.
    fetch(4'd9, 64'h0, 64'h61);
    fetch(4'd3, 64'h0, 64'h62);
    M_icode = 4'd7; M_cnd = 1'b0; M_valA = 64'h60;
    fetch(4'd3, 64'h0, 64'h6A);
    quiet();
    // halt at 0x70, then imem fault, each exited by mispredict.
    fetch(4'd3, 64'h0, 64'h70);
    fetch(4'd0, 64'h0, 64'h71);
    repeat (3) fetch(4'd3, 64'h0, 64'h77);
    M_icode = 4'd7; M_cnd = 1'b0; M_valA = 64'h90;
    fetch(4'd3, 64'h0, 64'h9A);
    quiet();
    f_imem_error = 1'b1;
    fetch(4'd3, 64'h0, 64'hA0);
    f_imem_error = 1'b0;
    fetch(4'd3, 64'h0, 64'hA4);
    M_icode = 4'd7; M_cnd = 1'b0; M_valA = 64'h30;
    fetch(4'd3, 64'h0, 64'h3A);
    quiet();
    // Stalls, then stall overridden by mispredict.
    F_stall = 1'b1;
    repeat (2) fetch(4'd3, 64'h0, 64'h3A);
    M_icode = 4'd7; M_cnd = 1'b0; M_valA = 64'hB0;
    fetch(4'd3, 64'h0, 64'hBA);
    quiet();
    // Stalled ret release keeps waiting.
    fetch(4'd9, 64'h0, 64'hBB);
    F_stall = 1'b1; W_icode = 4'd9; W_valM = 64'hC0;
    fetch(4'd3, 64'h0, 64'hCA);
    F_stall = 1'b0;
    fetch(4'd3, 64'h0, 64'hCA);
    quiet();
    // Asynchronous reset while waiting on ret.
    fetch(4'd9, 64'h0, 64'hCB);
    fetch(4'd3, 64'h0, 64'hCC);
    reset = 1'b1;
    fetch(4'd3, 64'h0, 64'hCC);
    reset = 1'b0;
    fetch(4'd3, 64'h0, 64'h10A);
    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3)       f_icode = 4'd0;
      else if (r < 6)  f_icode = 4'(12 + $urandom_range(0, 3));
      else if (r < 20) f_icode = 4'd7;
      else if (r < 28) f_icode = 4'd8;
      else if (r < 38) f_icode = 4'd9;
      else             f_icode = 4'(1 + $urandom_range(0, 5));
      f_valC       = {$urandom, $urandom};
      f_valP       = {$urandom, $urandom};
      f_imem_error = ($urandom_range(0, 99) < 3);
      F_stall      = ($urandom_range(0, 3) == 0);
      M_icode      = ($urandom_range(0, 99) < ((m_mode == 2) ? 25 : 10)) ? 4'd7 : 4'd5;
      M_cnd        = 1'($urandom_range(0, 1));
      M_valA       = {$urandom, $urandom};
      W_icode      = ($urandom_range(0, 99) < ((m_mode == 1) ? 35 : 8)) ? 4'd9 : 4'd4;
      W_valM       = {$urandom, $urandom};
      reset        = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    quiet();
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
